// File: rtl/systolic_pkg.sv
// Shared constants and state encoding for the systolic array sequencer.
package systolic_pkg;

  localparam int unsigned ADDR_W     = 11;
  localparam int unsigned DIM_W      = 5;
  localparam int unsigned BATCH_W    = 6;
  localparam int unsigned PIPE_EXTRA = 3;
  localparam int unsigned LAT_W      = 8;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Skew through the array plus the fixed buffer/PE register stages.
  function automatic logic [LAT_W-1:0] calc_latency(input logic [DIM_W-1:0] rows,
                                                    input logic [DIM_W-1:0] cols);
    return LAT_W'(rows) + LAT_W'(cols) + LAT_W'(PIPE_EXTRA);
  endfunction

endpackage

// File: rtl/seq_addr_gen.sv
// Loadable, increment-on-enable address counter; wraps modulo 2^W.
module seq_addr_gen #(
  parameter int unsigned W = 11
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] base,
  input  logic         inc,
  output logic [W-1:0] addr
);

  logic [W-1:0] addr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q <= '0;
    end else if (load) begin
      addr_q <= base;
    end else if (inc) begin
      addr_q <= addr_q + W'(1);
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/systolic_sequencer.sv
// Sequences one systolic array pass: activation reads, skewed psum read/write, done pulse.
module systolic_sequencer
  import systolic_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               weight_transfer,
  input  logic               systolic_start,
  input  logic [DIM_W-1:0]   last_row,
  input  logic [DIM_W-1:0]   last_col,
  input  logic [ADDR_W-1:0]  activations_addr_start,
  input  logic [ADDR_W-1:0]  partialsums_addr_start,
  input  logic [BATCH_W-1:0] batch,
  input  logic               accumulate,
  output logic               weight_load,
  output logic               act_rd_en,
  output logic [ADDR_W-1:0]  act_rd_addr,
  output logic               psum_rd_en,
  output logic [ADDR_W-1:0]  psum_rd_addr,
  output logic               psum_wr_en,
  output logic [ADDR_W-1:0]  psum_wr_addr,
  output logic               psum_accum,
  output logic               busy,
  output logic               done,
  output logic               start_dropped
);

  logic [1:0]         state_q, state_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic [LAT_W-1:0]   lat_q;
  logic [BATCH_W-1:0] batch_q;
  logic               accum_q;
  logic               weight_pend_q, weight_pend_d;
  logic               start_pend_q, start_pend_d;
  logic               weight_load_q, weight_load_d;
  logic               start_dropped_q, start_dropped_d;
  logic               snap_en;

  logic             in_run;
  logic [LAT_W-1:0] n_ext;
  logic [LAT_W-1:0] cnt_ahead;
  logic             last_cycle;

  assign in_run     = (state_q == StRun);
  assign n_ext      = LAT_W'(batch_q);
  assign cnt_ahead  = cnt_q + LAT_W'(1);
  assign last_cycle = (cnt_q == lat_q + n_ext - LAT_W'(1));

  // Reads lead writes by one cycle so read data lines up with the array output.
  assign act_rd_en  = in_run && (cnt_q < n_ext);
  assign psum_wr_en = in_run && (cnt_q >= lat_q) && (cnt_q < lat_q + n_ext);
  assign psum_rd_en = in_run && accum_q && (cnt_ahead >= lat_q) && (cnt_ahead < lat_q + n_ext);

  assign busy          = in_run;
  assign done          = (state_q == StDone);
  assign weight_load   = weight_load_q;
  assign start_dropped = start_dropped_q;
  assign psum_accum    = accum_q;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    weight_pend_d   = weight_pend_q;
    start_pend_d    = start_pend_q;
    weight_load_d   = 1'b0;
    start_dropped_d = 1'b0;
    snap_en         = 1'b0;

    case (state_q)
      StIdle: begin
        if (weight_pend_q || weight_transfer) begin
          weight_load_d = 1'b1;
          weight_pend_d = 1'b0;
          if (systolic_start) begin
            start_pend_d = 1'b1;
          end
        end else if (start_pend_q || systolic_start) begin
          start_pend_d = 1'b0;
          snap_en      = 1'b1;
          cnt_d        = '0;
          state_d      = (batch == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        cnt_d = cnt_ahead;
        if (last_cycle) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outside IDLE, weight requests queue but starts are rejected.
    if (state_q != StIdle) begin
      if (weight_transfer) begin
        weight_pend_d = 1'b1;
      end
      if (systolic_start) begin
        start_dropped_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      lat_q           <= '0;
      batch_q         <= '0;
      accum_q         <= 1'b0;
      weight_pend_q   <= 1'b0;
      start_pend_q    <= 1'b0;
      weight_load_q   <= 1'b0;
      start_dropped_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      weight_pend_q   <= weight_pend_d;
      start_pend_q    <= start_pend_d;
      weight_load_q   <= weight_load_d;
      start_dropped_q <= start_dropped_d;
      if (snap_en) begin
        lat_q   <= calc_latency(last_row, last_col);
        batch_q <= batch;
        accum_q <= accumulate;
      end
    end
  end

  seq_addr_gen #(.W(ADDR_W)) u_act_addr (
    .clk    (clk),
    .resetn (resetn),
    .load   (snap_en),
    .base   (activations_addr_start),
    .inc    (act_rd_en),
    .addr   (act_rd_addr)
  );

  seq_addr_gen #(.W(ADDR_W)) u_psum_rd_addr (
    .clk    (clk),
    .resetn (resetn),
    .load   (snap_en),
    .base   (partialsums_addr_start),
    .inc    (psum_rd_en),
    .addr   (psum_rd_addr)
  );

  seq_addr_gen #(.W(ADDR_W)) u_psum_wr_addr (
    .clk    (clk),
    .resetn (resetn),
    .load   (snap_en),
    .base   (partialsums_addr_start),
    .inc    (psum_wr_en),
    .addr   (psum_wr_addr)
  );

endmodule

// File: tb/tb_systolic_sequencer.sv
// Self-checking bench: timing-formula model, table vectors, random runs, corner sequences.
module tb_systolic_sequencer;

  logic        clk;
  logic        resetn;
  logic        weight_transfer;
  logic        systolic_start;
  logic [4:0]  last_row;
  logic [4:0]  last_col;
  logic [10:0] activations_addr_start;
  logic [10:0] partialsums_addr_start;
  logic [5:0]  batch;
  logic        accumulate;
  logic        weight_load;
  logic        act_rd_en;
  logic [10:0] act_rd_addr;
  logic        psum_rd_en;
  logic [10:0] psum_rd_addr;
  logic        psum_wr_en;
  logic [10:0] psum_wr_addr;
  logic        psum_accum;
  logic        busy;
  logic        done;
  logic        start_dropped;

  systolic_sequencer dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .weight_transfer        (weight_transfer),
    .systolic_start         (systolic_start),
    .last_row               (last_row),
    .last_col               (last_col),
    .activations_addr_start (activations_addr_start),
    .partialsums_addr_start (partialsums_addr_start),
    .batch                  (batch),
    .accumulate             (accumulate),
    .weight_load            (weight_load),
    .act_rd_en              (act_rd_en),
    .act_rd_addr            (act_rd_addr),
    .psum_rd_en             (psum_rd_en),
    .psum_rd_addr           (psum_rd_addr),
    .psum_wr_en             (psum_wr_en),
    .psum_wr_addr           (psum_wr_addr),
    .psum_accum             (psum_accum),
    .busy                   (busy),
    .done                   (done),
    .start_dropped          (start_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  lr;
    logic [4:0]  lc;
    logic [5:0]  b;
    logic [10:0] act;
    logic [10:0] ps;
    logic        acc;
  } cfg_t;

  typedef struct {
    cfg_t        cfg;
    int          exp_done;
    int          exp_act;
    int          exp_wr;
    int          exp_rd;
    logic [10:0] exp_last_act;
  } vec_t;

  int checks;
  int failures;
  int cur_s;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s (cycle offset %0d): got %0h required %0h", name, cur_s, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input cfg_t c);
    last_row               = c.lr;
    last_col               = c.lc;
    batch                  = c.b;
    activations_addr_start = c.act;
    partialsums_addr_start = c.ps;
    accumulate             = c.acc;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".weight_load"}, 32'(weight_load), 0);
    chk({tag, ".act_rd_en"}, 32'(act_rd_en), 0);
    chk({tag, ".act_rd_addr"}, 32'(act_rd_addr), 0);
    chk({tag, ".psum_rd_en"}, 32'(psum_rd_en), 0);
    chk({tag, ".psum_rd_addr"}, 32'(psum_rd_addr), 0);
    chk({tag, ".psum_wr_en"}, 32'(psum_wr_en), 0);
    chk({tag, ".psum_wr_addr"}, 32'(psum_wr_addr), 0);
    chk({tag, ".psum_accum"}, 32'(psum_accum), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".start_dropped"}, 32'(start_dropped), 0);
  endtask

  // Expected outputs at cycle S+s, derived from the run timing rules.
  task automatic check_cycle(input cfg_t c, input int s, input logic exp_wl, input logic exp_sd);
    int lat, n;
    logic busy_e, done_e, act_e, wr_e, rd_e;
    lat    = int'(c.lr) + int'(c.lc) + 3;
    n      = int'(c.b);
    cur_s  = s;
    busy_e = (n > 0) && (s >= 0) && (s < lat + n);
    done_e = (n == 0) ? (s == 0) : (s == lat + n);
    act_e  = (s >= 0) && (s < n);
    wr_e   = (s >= lat) && (s < lat + n);
    rd_e   = c.acc && (s >= lat - 1) && (s < lat - 1 + n);
    chk("busy", 32'(busy), 32'(busy_e));
    chk("done", 32'(done), 32'(done_e));
    chk("act_rd_en", 32'(act_rd_en), 32'(act_e));
    chk("psum_wr_en", 32'(psum_wr_en), 32'(wr_e));
    chk("psum_rd_en", 32'(psum_rd_en), 32'(rd_e));
    chk("weight_load", 32'(weight_load), 32'(exp_wl));
    chk("start_dropped", 32'(start_dropped), 32'(exp_sd));
    if (act_e) chk("act_rd_addr", 32'(act_rd_addr), (int'(c.act) + s) & 32'h7FF);
    if (wr_e) chk("psum_wr_addr", 32'(psum_wr_addr), (int'(c.ps) + s - lat) & 32'h7FF);
    if (rd_e) chk("psum_rd_addr", 32'(psum_rd_addr), (int'(c.ps) + s - lat + 1) & 32'h7FF);
    if (busy_e) chk("psum_accum", 32'(psum_accum), 32'(c.acc));
  endtask

  task automatic run_cfg(input cfg_t c, input bit scramble, output int done_at,
                         output int act_n, output int wr_n, output int rd_n,
                         output logic [10:0] last_act);
    int lat, n;
    lat      = int'(c.lr) + int'(c.lc) + 3;
    n        = int'(c.b);
    done_at  = -1;
    act_n    = 0;
    wr_n     = 0;
    rd_n     = 0;
    last_act = '0;
    apply(c);
    systolic_start = 1'b1;
    step();
    systolic_start = 1'b0;
    for (int s = 0; s <= lat + n + 1; s++) begin
      check_cycle(c, s, 1'b0, 1'b0);
      if (done && done_at < 0) done_at = s;
      if (act_rd_en) begin
        act_n++;
        last_act = act_rd_addr;
      end
      if (psum_wr_en) wr_n++;
      if (psum_rd_en) rd_n++;
      if (scramble) begin
        last_row               = 5'($urandom);
        last_col               = 5'($urandom);
        batch                  = 6'($urandom);
        activations_addr_start = 11'($urandom);
        partialsums_addr_start = 11'($urandom);
        accumulate             = 1'($urandom);
      end
      step();
    end
  endtask

  initial begin
    int done_at, act_n, wr_n, rd_n;
    logic [10:0] last_act;
    cfg_t c;

    checks   = 0;
    failures = 0;
    cur_s    = 0;

    tbl[0] = '{cfg: '{lr: 5'd1, lc: 5'd2, b: 6'd3, act: 11'h010, ps: 11'h020, acc: 1'b0},
               exp_done: 9, exp_act: 3, exp_wr: 3, exp_rd: 0, exp_last_act: 11'h012};
    tbl[1] = '{cfg: '{lr: 5'd1, lc: 5'd2, b: 6'd3, act: 11'h010, ps: 11'h020, acc: 1'b1},
               exp_done: 9, exp_act: 3, exp_wr: 3, exp_rd: 3, exp_last_act: 11'h012};
    tbl[2] = '{cfg: '{lr: 5'd0, lc: 5'd0, b: 6'd4, act: 11'h7FE, ps: 11'h100, acc: 1'b0},
               exp_done: 7, exp_act: 4, exp_wr: 4, exp_rd: 0, exp_last_act: 11'h001};
    tbl[3] = '{cfg: '{lr: 5'd3, lc: 5'd4, b: 6'd0, act: 11'h055, ps: 11'h066, acc: 1'b1},
               exp_done: 0, exp_act: 0, exp_wr: 0, exp_rd: 0, exp_last_act: 11'h000};

    resetn          = 1'b0;
    weight_transfer = 1'b0;
    systolic_start  = 1'b0;
    apply(tbl[0].cfg);
    #1;
    check_all_zero("reset");
    step();
    step();
    resetn = 1'b1;
    step();

    // Table-driven directed runs.
    for (int i = 0; i < 4; i++) begin
      run_cfg(tbl[i].cfg, 1'b0, done_at, act_n, wr_n, rd_n, last_act);
      cur_s = i;
      chk("tbl.done_at", done_at, tbl[i].exp_done);
      chk("tbl.act_count", act_n, tbl[i].exp_act);
      chk("tbl.wr_count", wr_n, tbl[i].exp_wr);
      chk("tbl.rd_count", rd_n, tbl[i].exp_rd);
      chk("tbl.last_act", 32'(last_act), 32'(tbl[i].exp_last_act));
    end

    // Back-to-back weight requests: one pulse each, block stays idle.
    weight_transfer = 1'b1;
    step();
    cur_s = 0;
    chk("wl_b2b.first", 32'(weight_load), 1);
    step();
    weight_transfer = 1'b0;
    chk("wl_b2b.second", 32'(weight_load), 1);
    chk("wl_b2b.busy", 32'(busy), 0);
    step();
    chk("wl_b2b.end", 32'(weight_load), 0);
    step();

    // Start + weight together, then weight and start during the run.
    c = tbl[0].cfg;
    apply(c);
    systolic_start  = 1'b1;
    weight_transfer = 1'b1;
    step();
    systolic_start  = 1'b0;
    weight_transfer = 1'b0;
    cur_s = -1;
    chk("coinc.weight_load", 32'(weight_load), 1);
    chk("coinc.busy", 32'(busy), 0);
    step();
    for (int s = 0; s <= 14; s++) begin
      check_cycle(c, s, 1'(s == 11), 1'(s == 2));
      weight_transfer = (s == 1);
      systolic_start  = (s == 1);
      step();
    end
    weight_transfer = 1'b0;
    systolic_start  = 1'b0;

    // Asynchronous reset mid-run with a weight request pending.
    c = tbl[1].cfg;
    apply(c);
    systolic_start = 1'b1;
    step();
    systolic_start = 1'b0;
    for (int s = 0; s <= 3; s++) begin
      check_cycle(c, s, 1'b0, 1'b0);
      weight_transfer = (s == 1);
      if (s < 3) step();
    end
    weight_transfer = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    cur_s = 3;
    check_all_zero("midrun_reset");
    step();
    step();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      cur_s = i;
      chk("post_reset.weight_load", 32'(weight_load), 0);
      chk("post_reset.busy", 32'(busy), 0);
    end
    run_cfg(tbl[0].cfg, 1'b0, done_at, act_n, wr_n, rd_n, last_act);
    chk("post_reset.done_at", done_at, tbl[0].exp_done);
    chk("post_reset.wr_count", wr_n, tbl[0].exp_wr);

    // Random runs; config inputs are scrambled during each run.
    for (int i = 0; i < 24; i++) begin
      c.lr  = 5'($urandom_range(0, 31));
      c.lc  = 5'($urandom_range(0, 31));
      c.b   = 6'($urandom_range(0, 63));
      c.act = 11'($urandom);
      c.ps  = 11'($urandom);
      c.acc = 1'($urandom);
      if (i % 4 == 0) c.act = 11'h7F0 + 11'($urandom_range(0, 15));
      run_cfg(c, 1'b1, done_at, act_n, wr_n, rd_n, last_act);
      cur_s = i;
      chk("rand.done_at", done_at,
          (c.b == 0) ? 0 : int'(c.lr) + int'(c.lc) + 3 + int'(c.b));
      chk("rand.wr_count", wr_n, int'(c.b));
      chk("rand.rd_count", rd_n, c.acc ? int'(c.b) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_sequencer.md
# systolic_sequencer

Sequences one pass of the binary systolic array from the write-only APB configuration registers. On a start pulse it snapshots the configuration and streams `batch` activation vectors out of the activation buffers. It then accounts for the array's row/column skew and writes (or read-modify-writes) the matching partial-sum accumulator entries, signalling completion with a `done` pulse. It sits between the APB register block and the activation buffers, the systolic array and the accumulator memory, and also serialises weight-transfer requests against array runs.

## Interface
- `ADDR_W`, 11: activation/partial-sum address width.
- `DIM_W`, 5: width of `last_row`/`last_col`.
- `BATCH_W`, 6: width of `batch`.
- `PIPE_EXTRA`, 3: fixed latency = 1 buffer read + 1 PE input reg + 1 PE output reg.
- `clk` in 1: the single clock; all logic on its rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `weight_transfer`, `systolic_start` in 1: one-cycle request pulses from the register block.
- `last_row`, `last_col` in DIM_W: last active row/column index.
- `activations_addr_start`, `partialsums_addr_start` in ADDR_W: base addresses.
- `batch` in BATCH_W: vectors per run, N.
- `accumulate` in 1: 1 = add into existing sums, 0 = overwrite.
- `weight_load` out 1: one-cycle pulse telling the array to latch buffered weights.
- `act_rd_en` out 1, `act_rd_addr` out ADDR_W: activation buffer read.
- `psum_rd_en` out 1, `psum_rd_addr` out ADDR_W: accumulator read; used only when accumulating.
- `psum_wr_en` out 1, `psum_wr_addr` out ADDR_W: accumulator write.
- `psum_accum` out 1: snapshot of `accumulate`, valid for the whole run.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle completion pulse.
- `start_dropped` out 1: one-cycle pulse when a start arrives during RUN.

## Operation
- States:
  - IDLE: waiting for requests.
  - RUN: streaming and draining.
  - DONE: a single cycle that pulses `done`.
- Config snapshot: on an accepted start, latch `last_row`, `last_col`, both base addresses, `batch` and `accumulate`. Input changes during RUN have no effect.
- Latency L = `last_row` + `last_col` + PIPE_EXTRA; maximum 65.
- An 8-bit cycle counter c counts from 0 in RUN. The run ends when c = L+N-1.
- Activation reads: for c in 0..N-1, `act_rd_en`=1 and `act_rd_addr` = act_base + c.
- Partial-sum writes: for c in L..L+N-1, `psum_wr_en`=1 and `psum_wr_addr` = ps_base + (c-L).
- Partial-sum reads: when accumulating, `psum_rd_en`=1 at c = L-1+k with `psum_rd_addr` = ps_base + k, for k = 0..N-1.
- All address arithmetic is modulo 2^ADDR_W, so addresses wrap silently.
- N=0: start goes straight to DONE. No read or write enables assert.
- IDLE priority: a pending or new weight request is served before a pending or new start.
  - `weight_load` pulses for one cycle.
  - The start is held in `start_pend` and accepted on the following IDLE cycle.
- `weight_transfer` during RUN/DONE sets `weight_pend`, which is served in the next IDLE cycle.
- `systolic_start` during RUN/DONE is not queued and pulses `start_dropped`.
- Reset (asynchronous, any time, including mid-run):
  - state goes to IDLE;
  - pending flags, counter and snapshots clear to 0;
  - every output goes to 0 immediately.

## Timing
- All outputs are registered (Moore). T is the edge that samples `systolic_start` in IDLE with no weight request; S = T+1 is the first RUN cycle.
- `busy` is high for cycles S..S+L+N-1.
- `done` is high at S+L+N, then the block returns to IDLE at S+L+N+1.
- For N=0, `done` is high at S and `busy` never rises.
- When a weight request is sampled at edge T, `weight_load` is high during T+1 and the block stays in IDLE. Back-to-back weight requests yield one pulse per request.
- When a start and a weight request coincide at T:
  - `weight_load` is high at T+1;
  - the start is accepted at edge T+1;
  - S = T+2.
- A new start is accepted at the earliest on the edge ending the IDLE cycle after DONE.

## Structure
- Shared package `systolic_pkg` holds:
  - state enum {IDLE, RUN, DONE};
  - ADDR_W, DIM_W, BATCH_W, PIPE_EXTRA;
  - the latency width constant (8).
- One natural sub-module, `seq_addr_gen`: load base, increment-on-enable, wrapping ADDR_W counter. It is instantiated for activation read, psum read and psum write addresses.

## Test plan
- last_row=1, last_col=2, batch=3, act=0x010, ps=0x020, accumulate=0 → L=6; act reads S..S+2 at 0x010..0x012; psum writes S+6..S+8 at 0x020..0x022; `psum_rd_en` never asserts; `done` at S+9.
- Same config with accumulate=1 → `psum_rd_en` at S+5..S+7 at 0x020..0x022; writes unchanged; `psum_accum`=1 throughout.
- act=0x7FE, batch=4, last_row=last_col=0 → reads 0x7FE, 0x7FF, 0x000, 0x001; `done` at S+7.
- batch=0 → `done` at S; no enables; `busy` stays 0.
- Start and weight_transfer in the same cycle → `weight_load` at T+1, S=T+2. Weight at S+1 → `weight_load` in the cycle after the first post-DONE IDLE cycle. Start at S+1 → `start_dropped` pulse, no second run.
- `resetn` low at S+3 of the first scenario → all outputs 0 asynchronously. After release, no pending flags remain and a fresh start runs normally.
